// File: rtl/io_pkg.sv
// Shared types and widths for the I/O issue unit.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IN_WAIT  = 2'd1,
        OUT_WAIT = 2'd2
    } io_state_t;

    localparam int IO_BYTE_W = 8;
    localparam int IO_WORD_W = 32;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty disambiguation.
// Pushes into a full FIFO and pops from an empty FIFO are ignored, so a
// simultaneous push+pop on a full FIFO only pops and on an empty FIFO only pushes.
module io_fifo
    import io_pkg::*;
#(
    parameter int WIDTH = IO_BYTE_W,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/io_issue_unit.sv
// Execute-stage responder for in/out instructions, bridging the pipeline to a
// UART byte stream via a TX FIFO and an RX FIFO.
// Optional feature macro: IO_STALL_CNT_EN adds a saturating stall-cycle counter
// on the stall_cycles port.
module io_issue_unit
    import io_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 out_issued,
    input  logic [IO_BYTE_W-1:0] out_data,
    input  logic                 in_issued,
    input  logic                 flush,
    output logic [IO_WORD_W-1:0] in_data,
    output logic                 in_valid,
    output logic                 io_stall,
    output logic [IO_BYTE_W-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [IO_BYTE_W-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
`ifdef IO_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    io_state_t            state;
    io_state_t            state_next;
    logic                 tx_push;
    logic                 tx_empty;
    logic                 tx_full;
    logic                 rx_pop;
    logic                 rx_empty;
    logic                 rx_full;
    logic [IO_BYTE_W-1:0] rx_head;

    io_fifo #(.WIDTH(IO_BYTE_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (tx_push),
        .wdata (out_data),
        .pop   (tx_ready),
        .head  (tx_data),
        .empty (tx_empty),
        .full  (tx_full)
    );

    io_fifo #(.WIDTH(IO_BYTE_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_valid),
        .wdata (rx_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign in_data  = rx_empty ? '0 : {{(IO_WORD_W-IO_BYTE_W){1'b0}}, rx_head};

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state: wait states are left as soon as the blocking FIFO condition clears.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_issued) begin
                        if (rx_empty) state_next = IN_WAIT;
                    end else if (out_issued && tx_full) begin
                        state_next = OUT_WAIT;
                    end
                end
                IN_WAIT:  if (!rx_empty) state_next = IDLE;
                OUT_WAIT: if (!tx_full)  state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Outputs: in wins over out, flush kills everything, reset releases the stall at once.
    always_comb begin
        io_stall = 1'b0;
        in_valid = 1'b0;
        rx_pop   = 1'b0;
        tx_push  = 1'b0;
        if (rstn && !flush) begin
            case (state)
                IDLE: begin
                    if (in_issued) begin
                        if (rx_empty) begin
                            io_stall = 1'b1;
                        end else begin
                            in_valid = 1'b1;
                            rx_pop   = 1'b1;
                        end
                    end else if (out_issued) begin
                        if (tx_full) io_stall = 1'b1;
                        else         tx_push  = 1'b1;
                    end
                end
                IN_WAIT: begin
                    if (rx_empty) begin
                        io_stall = 1'b1;
                    end else begin
                        in_valid = 1'b1;
                        rx_pop   = 1'b1;
                    end
                end
                OUT_WAIT: begin
                    if (tx_full) io_stall = 1'b1;
                    else         tx_push  = 1'b1;
                end
                default: begin
                    io_stall = 1'b0;
                end
            endcase
        end
    end

`ifdef IO_STALL_CNT_EN
    // Saturating count of stalled cycles, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (io_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_issue_unit.sv
// Self-checking bench for io_issue_unit: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_io_issue_unit;

    localparam int TXD = 16;
    localparam int RXD = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        out_issued = 1'b0;
    logic [7:0]  out_data = 8'h00;
    logic        in_issued = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] in_data;
    logic        in_valid;
    logic        io_stall;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
`ifdef IO_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    io_issue_unit #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .out_issued (out_issued),
        .out_data   (out_data),
        .in_issued  (in_issued),
        .flush      (flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .io_stall   (io_stall),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready)
`ifdef IO_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: byte queues plus the pending (blocked) request kind.
    byte unsigned txq[$];
    byte unsigned rxq[$];
    int           pend = 0;     // 0 none, 1 blocked in, 2 blocked out
    longint       cnt_m = 0;
    logic         last_stall = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        pend = 0;
        cnt_m = 0;
        last_stall = 1'b0;
    endtask

    task automatic idle_inputs();
        in_issued  = 1'b0;
        out_issued = 1'b0;
        flush      = 1'b0;
        rx_valid   = 1'b0;
    endtask

    // One clock: inputs are already set at the falling edge; check, then advance.
    task automatic cycle();
        logic        e_stall;
        logic        e_inv;
        logic        do_rxpop;
        logic        do_txpush;
        logic        do_txpop;
        logic        do_rxpush;
        logic [31:0] e_data;
        logic [7:0]  push_byte;
        logic [7:0]  rx_byte;
        int          np;
        e_stall = 1'b0; e_inv = 1'b0; do_rxpop = 1'b0; do_txpush = 1'b0;
        #1;
        np = pend;
        if (flush) begin
            np = 0;
        end else if (pend == 1 || (pend == 0 && in_issued)) begin
            if (rxq.size() > 0) begin
                e_inv = 1'b1; do_rxpop = 1'b1; np = 0;
            end else begin
                e_stall = 1'b1; np = 1;
            end
        end else if (pend == 2 || (pend == 0 && out_issued)) begin
            if (txq.size() < TXD) begin
                do_txpush = 1'b1; np = 0;
            end else begin
                e_stall = 1'b1; np = 2;
            end
        end
        e_data = (rxq.size() > 0) ? {24'h0, rxq[0]} : 32'h0;
        chk("io_stall", {31'h0, io_stall}, {31'h0, e_stall});
        chk("in_valid", {31'h0, in_valid}, {31'h0, e_inv});
        if (e_inv || rxq.size() == 0) chk("in_data", in_data, e_data);
        chk("tx_valid", {31'h0, tx_valid}, {31'h0, (txq.size() > 0)});
        if (txq.size() > 0) chk("tx_data", {24'h0, tx_data}, {24'h0, txq[0]});
        chk("rx_ready", {31'h0, rx_ready}, {31'h0, (rxq.size() < RXD)});
`ifdef IO_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, cnt_m[31:0]);
`endif
        do_txpop   = tx_ready && (txq.size() > 0);
        do_rxpush  = rx_valid && (rxq.size() < RXD);
        push_byte  = out_data;
        rx_byte    = rx_data;
        last_stall = e_stall;
        @(posedge clk);
        if (do_txpop)  void'(txq.pop_front());
        if (do_txpush) txq.push_back(push_byte);
        if (do_rxpop)  void'(rxq.pop_front());
        if (do_rxpush) rxq.push_back(rx_byte);
        if (e_stall && cnt_m != 64'h0000_0000_FFFF_FFFF) cnt_m++;
        pend = np;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_io_stall"}, {31'h0, io_stall}, 32'h0);
        chk({pfx, "_in_valid"}, {31'h0, in_valid}, 32'h0);
        chk({pfx, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
        chk({pfx, "_rx_ready"}, {31'h0, rx_ready}, 32'h1);
        chk({pfx, "_in_data"},  in_data, 32'h0);
`ifdef IO_STALL_CNT_EN
        chk({pfx, "_stall_cycles"}, stall_cycles, 32'h0);
`endif
    endtask

    initial begin
        // Reset
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rstn = 1'b1;

        // RX preloaded with three bytes, then three back-to-back in requests
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_data = 8'h41 + 8'(i);
            cycle();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_issued = 1'b1;
            cycle();
        end
        in_issued = 1'b0;
        cycle();

        // RX empty: in held, byte arrives on cycle 4, completes on cycle 5
        in_issued = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rx_valid = (i == 4);
            rx_data  = 8'h7F;
            cycle();
        end
        idle_inputs();
        cycle();

        // TX full with backpressure, then release and drain
        tx_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            out_issued = 1'b1; out_data = 8'(k);
            cycle();
        end
        tx_ready = 1'b1;
        for (int n = 0; n < 10 && last_stall; n++) cycle();
        out_issued = 1'b0;
        for (int n = 0; n < 200 && txq.size() > 0; n++) begin
            tx_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        chk("tx_drained", {31'h0, tx_valid}, 32'h0);

        // RX full: 16 bytes, 17th held until an in request frees a slot
        for (int k = 0; k < RXD; k++) begin
            rx_valid = 1'b1; rx_data = 8'h80 + 8'(k);
            cycle();
        end
        rx_data = 8'hEE;
        cycle();
        in_issued = 1'b1;
        cycle();
        in_issued = 1'b0;
        for (int n = 0; n < 5 && rx_valid && !(rxq.size() < RXD); n++) cycle();
        cycle();
        rx_valid = 1'b0;
        for (int n = 0; n < 40 && rxq.size() > 0; n++) begin
            in_issued = 1'b1;
            cycle();
        end
        in_issued = 1'b0;
        cycle();

        // Flush with a pending in request and data present, then replay
        rx_valid = 1'b1; rx_data = 8'h55;
        cycle();
        rx_valid = 1'b0;
        flush = 1'b1; in_issued = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        in_issued = 1'b0;
        cycle();
        // Flush while blocked in IN_WAIT
        in_issued = 1'b1;
        cycle();
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_issued = 1'b0;
        cycle();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if (!last_stall) begin
                int r;
                r = $urandom_range(0, 9);
                in_issued  = (r < 3) || (r == 9);
                out_issued = (r >= 3 && r < 6) || (r == 9);
                out_data   = 8'($urandom);
            end
            flush = ($urandom_range(0, 15) == 0);
            if (!(rx_valid && rxq.size() >= RXD)) begin
                rx_valid = ($urandom_range(0, 2) == 0);
                rx_data  = 8'($urandom);
            end
            tx_ready = ($urandom_range(0, 3) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        // Reset asserted while blocked in OUT_WAIT
        tx_ready = 1'b0;
        for (int n = 0; n < 40 && !last_stall; n++) begin
            out_issued = 1'b1; out_data = 8'(n);
            cycle();
        end
        chk("out_wait_reached", {31'h0, io_stall}, 32'h1);
        #2 rstn = 1'b0;
        #1 check_reset_values("midrst");
        model_reset();
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cycle();

        // Five stalled cycles, then flush
        in_issued = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        flush = 1'b1;
        cycle();
`ifdef IO_STALL_CNT_EN
        chk("stall_cnt_5", stall_cycles, 32'd5);
`endif
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
